// File: rtl/seq_ctrl_if.sv
// Pattern playback controller bus: buffer write port, run control and playback status.
interface seq_ctrl_if #(
    parameter int N     = 1,
    parameter int DEPTH = 16,
    parameter int CNTW  = 8
);
    localparam int AW = $clog2(DEPTH);

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [N-1:0]    wr_data;
    logic [AW:0]     len;
    logic [CNTW-1:0] reps;
    logic            start;
    logic            pause;
    logic            stop;

    logic [N-1:0]    dout;
    logic            active;
    logic [AW-1:0]   step_idx;
    logic [CNTW-1:0] rep_cnt;
    logic            done;

    // Bench / sequencer side
    modport master (
        output wr_en, wr_addr, wr_data, len, reps, start, pause, stop,
        input  dout, active, step_idx, rep_cnt, done
    );

    // Controller side
    modport slave (
        input  wr_en, wr_addr, wr_data, len, reps, start, pause, stop,
        output dout, active, step_idx, rep_cnt, done
    );
endinterface

// File: rtl/seq_ctrl.sv
// Pattern playback controller: plays a writable buffer of N-bit elements one per
// clock with programmable length, repeat count (0 = forever), pause and abort.
module seq_ctrl #(
    parameter int N     = 1,
    parameter int DEPTH = 16,
    parameter int CNTW  = 8
) (
    input  logic         clock,
    input  logic         resetn,
    seq_ctrl_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]     LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     LEN_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   STEP_ONE = AW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_PAUSE
    } state_t;

    logic [N-1:0]    mem_q [DEPTH];

    state_t          state_q,  state_d;
    logic [N-1:0]    dout_q,   dout_d;
    logic            active_q, active_d;
    logic [AW-1:0]   step_q,   step_d;
    logic [CNTW-1:0] rep_q,    rep_d;
    logic            done_q,   done_d;
    logic [AW:0]     len_q,    len_d;
    logic [CNTW-1:0] reps_q,   reps_d;

    logic [AW-1:0]   step_nxt;

    assign step_nxt = step_q + STEP_ONE;

    // Pattern buffer write port; contents survive reset
    always_ff @(posedge clock) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            dout_q   <= '0;
            active_q <= 1'b0;
            step_q   <= '0;
            rep_q    <= '0;
            done_q   <= 1'b0;
            len_q    <= '0;
            reps_q   <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            active_q <= active_d;
            step_q   <= step_d;
            rep_q    <= rep_d;
            done_q   <= done_d;
            len_q    <= len_d;
            reps_q   <= reps_d;
        end
    end

    // Next-state and next-output decode; stop beats pause beats advance/completion
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        step_d  = step_q;
        rep_d   = rep_q;
        len_d   = len_q;
        reps_d  = reps_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    len_d   = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
                    reps_d  = bus.reps;
                    dout_d  = mem_q[0];
                    step_d  = '0;
                    rep_d   = '0;
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    dout_d  = '0;
                    step_d  = '0;
                end else if (bus.pause) begin
                    state_d = S_PAUSE;
                end else if ({1'b0, step_q} < (len_q - LEN_ONE)) begin
                    step_d = step_nxt;
                    dout_d = mem_q[step_nxt];
                end else if ((reps_q != '0) && (rep_q == (reps_q - CNT_ONE))) begin
                    state_d = S_IDLE;
                    dout_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    step_d = '0;
                    rep_d  = rep_q + CNT_ONE;
                    dout_d = mem_q[0];
                end
            end

            S_PAUSE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    dout_d  = '0;
                    step_d  = '0;
                end else if (!bus.pause) begin
                    // Resume without advancing so the held element gets a full PLAY cycle
                    state_d = S_PLAY;
                end
            end

            default: begin
                state_d = S_IDLE;
                dout_d  = '0;
                step_d  = '0;
            end
        endcase

        active_d = (state_d != S_IDLE);
    end

    assign bus.dout     = dout_q;
    assign bus.active   = active_q;
    assign bus.step_idx = step_q;
    assign bus.rep_cnt  = rep_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: the driver pushes hand-derived expected outputs
// per clock, a negedge monitor pops and compares them against the DUT.
module tb_seq_ctrl;
    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int CNTW  = 8;

    localparam logic [4:0] M_ALL    = 5'h1F;
    localparam logic [4:0] M_NOSI   = 5'h0F;
    localparam logic [4:0] M_NORC   = 5'h17;
    localparam logic [4:0] M_NORCSI = 5'h07;

    typedef struct {
        string      tag;
        logic [3:0] d;
        logic       a;
        logic       dn;
        logic [7:0] rc;
        logic [3:0] si;
        logic [4:0] m;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    exp_t q[$];
    logic [3:0] pat [16];

    seq_ctrl_if #(.N(N), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

    seq_ctrl #(.N(N), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.m[0]) begin
                checks++;
                if (bus.dout !== e.d) begin
                    errors++;
                    $display("FAIL %s dout got %0d exp %0d", e.tag, bus.dout, e.d);
                end
            end
            if (e.m[1]) begin
                checks++;
                if (bus.active !== e.a) begin
                    errors++;
                    $display("FAIL %s active got %0b exp %0b", e.tag, bus.active, e.a);
                end
            end
            if (e.m[2]) begin
                checks++;
                if (bus.done !== e.dn) begin
                    errors++;
                    $display("FAIL %s done got %0b exp %0b", e.tag, bus.done, e.dn);
                end
            end
            if (e.m[3]) begin
                checks++;
                if (bus.rep_cnt !== e.rc) begin
                    errors++;
                    $display("FAIL %s rep_cnt got %0d exp %0d", e.tag, bus.rep_cnt, e.rc);
                end
            end
            if (e.m[4]) begin
                checks++;
                if (bus.step_idx !== e.si) begin
                    errors++;
                    $display("FAIL %s step_idx got %0d exp %0d", e.tag, bus.step_idx, e.si);
                end
            end
        end
    end

    // One clock: inputs already set, record what must be visible after the edge
    task automatic cyc(input string tag, input logic [3:0] d, input logic a,
                       input logic dn, input logic [7:0] rc, input logic [3:0] si,
                       input logic [4:0] m);
        exp_t e;
        @(posedge clk);
        #1;
        e.tag = tag; e.d = d; e.a = a; e.dn = dn; e.rc = rc; e.si = si; e.m = m;
        q.push_back(e);
    endtask

    task automatic play(input string tag, input int idx, input int rep);
        cyc(tag, pat[idx], 1'b1, 1'b0, 8'(rep), 4'(idx), M_ALL);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn       = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.len      = '0;
        bus.reps     = '0;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.stop     = 1'b0;
        for (int i = 0; i < 16; i++) pat[i] = 4'(i + 1);

        cyc("reset0", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_ALL);
        cyc("reset1", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_ALL);
        resetn = 1'b1;

        // Fill buffer with 1..15,0
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(i);
            bus.wr_data = pat[i];
            cyc("wr_idle", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_ALL);
        end
        bus.wr_en = 1'b0;

        // Finite run: len 4, reps 2
        bus.len = 5'd4; bus.reps = 8'd2; bus.start = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                play("run2", i, p);
                bus.start = 1'b0;
            end
        end
        cyc("run2_done", 4'd0, 1'b0, 1'b1, 8'd1, 4'd0, M_NOSI);

        // Start right after done; mid-run start and len/reps changes ignored
        bus.len = 5'd4; bus.reps = 8'd1; bus.start = 1'b1;
        play("restart", 0, 0);
        bus.start = 1'b0;
        play("restart", 1, 0);
        bus.start = 1'b1; bus.len = 5'd2; bus.reps = 8'd5;
        play("midstart", 2, 0);
        bus.start = 1'b0;
        play("midstart", 3, 0);
        cyc("restart_done", 4'd0, 1'b0, 1'b1, 8'd0, 4'd0, M_NOSI);
        cyc("done_pulse", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_NOSI);

        // Loop forever then stop
        bus.len = 5'd4; bus.reps = 8'd0; bus.start = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                play("loop", i, p);
                bus.start = 1'b0;
            end
        end
        play("loop", 0, 3);
        play("loop", 1, 3);
        bus.stop = 1'b1;
        cyc("loop_stop", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_NORC);
        bus.stop = 1'b0;
        cyc("loop_idle", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_NORC);

        // Pause held three edges while dout=2
        bus.len = 5'd4; bus.reps = 8'd1; bus.start = 1'b1;
        play("pause", 0, 0);
        bus.start = 1'b0;
        play("pause", 1, 0);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) play("paused", 1, 0);
        bus.pause = 1'b0;
        play("resume", 1, 0);
        play("resume", 2, 0);
        play("resume", 3, 0);
        cyc("pause_done", 4'd0, 1'b0, 1'b1, 8'd0, 4'd0, M_NOSI);

        // Stop and pause together
        bus.len = 5'd4; bus.reps = 8'd0; bus.start = 1'b1;
        play("stoppause", 0, 0);
        bus.start = 1'b0;
        play("stoppause", 1, 0);
        bus.stop = 1'b1; bus.pause = 1'b1;
        cyc("stoppause_abort", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_NORC);
        bus.stop = 1'b0; bus.pause = 1'b0;
        cyc("stoppause_idle", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_NORC);

        // len=0 start ignored
        bus.len = 5'd0; bus.reps = 8'd1; bus.start = 1'b1;
        cyc("len0", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_NORCSI);
        cyc("len0", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_NORCSI);
        bus.start = 1'b0;

        // len=20 clamps to 16
        bus.len = 5'd20; bus.reps = 8'd1; bus.start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            play("clamp", i, 0);
            bus.start = 1'b0;
        end
        cyc("clamp_done", 4'd0, 1'b0, 1'b1, 8'd0, 4'd0, M_NOSI);

        // len=1: constant element, rep_cnt every cycle
        bus.len = 5'd1; bus.reps = 8'd3; bus.start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            play("len1", 0, r);
            bus.start = 1'b0;
        end
        cyc("len1_done", 4'd0, 1'b0, 1'b1, 8'd2, 4'd0, M_NOSI);

        // Write mem[2]=9 while dout shows mem[1]: visible on next pass only
        bus.len = 5'd4; bus.reps = 8'd2; bus.start = 1'b1;
        play("wrrun", 0, 0);
        bus.start = 1'b0;
        play("wrrun", 1, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 4'd9;
        play("wrrun_old", 2, 0);
        bus.wr_en = 1'b0;
        pat[2] = 4'd9;
        play("wrrun", 3, 0);
        for (int i = 0; i < 4; i++) play("wrrun_new", i, 1);
        cyc("wrrun_done", 4'd0, 1'b0, 1'b1, 8'd1, 4'd0, M_NOSI);

        // Reset mid-run
        bus.len = 5'd4; bus.reps = 8'd0; bus.start = 1'b1;
        play("midrst", 0, 0);
        bus.start = 1'b0;
        play("midrst", 1, 0);
        resetn = 1'b0;
        cyc("midrst_reset", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_ALL);
        resetn = 1'b1;
        cyc("midrst_idle", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, M_ALL);

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Pattern playback controller for the stimulus sequence generators used in the SVA demo benches. Holds a small writable pattern buffer of N-bit values and plays it out on `dout` one element per clock, with programmable length, repeat count, pause and abort. It sits between the bench top level and the properties under test, replacing fixed compile-time sequence strings when a demo needs restartable or looped stimulus.

## Interface
- `N`, default 1: width of each pattern element and of `dout`; legal range 1..4.
- `DEPTH`, default 16: pattern buffer entries; power of two, at least 2. AW = $clog2(DEPTH).
- `CNTW`, default 8: width of the repeat count and counter.

- `clock`, in, 1: sole clock; everything updates on the rising edge.
- `resetn`, in, 1: reset, synchronous and active-low.
- `wr_en`, in, 1: write `wr_data` into buffer entry `wr_addr`.
- `wr_addr`, in, AW: buffer write address.
- `wr_data`, in, N: buffer write data.
- `len`, in, AW+1: pattern length in elements; sampled on start.
- `reps`, in, CNTW: repeat count; 0 means loop forever; sampled on start.
- `start`, in, 1: begin playback; honoured only in IDLE.
- `pause`, in, 1: level; freezes playback while high.
- `stop`, in, 1: abort playback.
- `dout`, out, N: current pattern element; 0 when not playing.
- `active`, out, 1: high in PLAY and PAUSE.
- `step_idx`, out, AW: buffer index currently driven on `dout`.
- `rep_cnt`, out, CNTW: completed passes in the current run.
- `done`, out, 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, PLAY, PAUSE. All outputs are registered.
- Reset (`resetn` low at an edge): state IDLE; `dout`=0, `active`=0, `step_idx`=0, `rep_cnt`=0, `done`=0. The buffer contents are not reset.
- The buffer writes on any edge with `wr_en` high, in any state. Reads use pre-edge contents, so a same-cycle write to the address being read shows up on the next pass only.
- IDLE, `start`=1, `len`!=0: latch len_l = min(`len`, DEPTH) and reps_l = `reps`. Then `dout`<=mem[0], `step_idx`<=0, `rep_cnt`<=0, go to PLAY. If `len`=0, `start` is ignored.
- In PLAY or PAUSE, `start` is ignored. Later changes to `len` or `reps` have no effect until the next start.
- PLAY edge, no stop, no pause:
  - If `step_idx` < len_l-1: `step_idx`+1, `dout`<=mem[`step_idx`+1].
  - Otherwise the pass ends. If reps_l!=0 and `rep_cnt`=reps_l-1: go to IDLE, `dout`<=0, `done`<=1, `rep_cnt` holds its final value.
  - Otherwise `step_idx`<=0, `rep_cnt`+1 (wraps modulo 2^CNTW when reps_l=0), `dout`<=mem[0].
- PLAY edge, `pause`=1: go to PAUSE; `dout`, `step_idx` and `rep_cnt` hold.
- PAUSE edge, `pause`=0: return to PLAY with no advance on that edge. Advancing resumes on the following edge, so every element is still presented for at least one full PLAY cycle.
- `stop`=1 in PLAY or PAUSE: go to IDLE; `dout`<=0, `step_idx`<=0; no `done`. `stop` has priority over `pause` and over completion in the same cycle.
- `done` is high for exactly one cycle, then low.
- A start in the cycle immediately after `done` is honoured.

## Timing
- Start latency: `start` sampled at edge k, so mem[0] is on `dout` after edge k and `active`=1 after edge k.
- Without pause, each element is held exactly one cycle. A finite run occupies len_l*reps_l cycles.
- `done` and `dout`=0 appear at the edge after the last element's cycle; `active` falls at that same edge.
- `stop` takes effect at the sampling edge: `dout`=0 from that edge on.
- `resetn` low mid-run behaves as reset at that edge, with no `done`.
- len_l=1: `dout` is constant at mem[0] for reps_l cycles; `rep_cnt` increments every cycle.

## Test plan
- N=4, DEPTH=16: write mem[0..3]=1,2,3,4; len=4, reps=2; pulse start. Required: `dout`=1,2,3,4,1,2,3,4 on 8 consecutive cycles, then 0 with `done` high for 1 cycle, `rep_cnt`=1.
- Same setup with reps=0: the pattern repeats indefinitely; `rep_cnt` counts 0,1,2,… (once every 4 cycles); `done` never asserts. Then stop: `dout`=0 and `active`=0 at the next edge, no `done`.
- Pause held 3 cycles while `dout`=2: `dout` stays 2 for 1+3+1 cycles, then 3,4; total run length grows by exactly 4 cycles.
- Stop and pause asserted together during PLAY: state goes to IDLE, `dout`=0, no `done`. `start` pulsed mid-run: ignored, sequence unchanged.
- len=0 with start: stays IDLE, `dout`=0. len=20 with DEPTH=16: plays 16 elements per pass.
- Write mem[2]=9 in the same cycle `dout` shows mem[1], during pass 1 of reps=2 (old mem[2]=3): this pass shows 3 at index 2, next pass shows 9. Also: `resetn` low mid-run forces all outputs to 0 at the next edge.
